// File: rtl/rate_spike_encoder.sv
// Bernoulli rate coder: one pixel per frame becomes NUM_STEPS spike timesteps,
// with spike odds set by comparing a Galois LFSR sample against the pixel.
module rate_spike_encoder #(
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_STEPS  = 16,
  parameter int          STEP_GAP   = 0,
  parameter int          COUNT_W    = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixel_valid,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  pixel_ready,
  input  logic                  abort,
  output logic                  spike_out,
  output logic                  spike_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [COUNT_W-1:0]    spike_count
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int SW = $clog2(NUM_STEPS + 1);
  localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
  localparam logic [SW-1:0] ALL_STEPS = SW'(NUM_STEPS);
  localparam logic [GW-1:0] LAST_GAP  = GW'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, STEP, GAP, DONE} state_t;

  state_t                state, state_d;
  logic [15:0]           lfsr, lfsr_nxt;
  logic [DATA_WIDTH-1:0] pix;
  logic [SW-1:0]         step_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [COUNT_W-1:0]    run_cnt;
  logic                  accept, issue, finish, spike;

  assign pixel_ready = (state == IDLE);
  assign lfsr_nxt    = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  // Full-scale pixel must spike on every step, which r < pix alone cannot give.
  assign spike       = (pix == {DATA_WIDTH{1'b1}}) | (lfsr_nxt[DATA_WIDTH-1:0] < pix);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (pixel_valid && !abort) begin
        accept  = 1'b1;
        state_d = STEP;
      end
      STEP: if (abort) state_d = IDLE;
      else begin
        issue = 1'b1;
        if (STEP_GAP > 0)                state_d = GAP;
        else if (step_cnt == LAST_STEP)  state_d = DONE;
      end
      GAP: if (abort) state_d = IDLE;
      else if (gap_cnt == LAST_GAP) state_d = (step_cnt == ALL_STEPS) ? DONE : STEP;
      DONE: begin
        state_d = IDLE;
        finish  = !abort;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= SEED;
      pix         <= '0;
      step_cnt    <= '0;
      gap_cnt     <= '0;
      run_cnt     <= '0;
      spike_out   <= 1'b0;
      spike_valid <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      spike_count <= '0;
    end else begin
      spike_out   <= 1'b0;
      spike_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (accept) begin
        pix      <= pixel_data;
        step_cnt <= '0;
        gap_cnt  <= '0;
        run_cnt  <= '0;
        busy     <= 1'b1;
      end
      // LFSR only moves on issued timesteps so the sequence spans frames.
      if (issue) begin
        lfsr        <= lfsr_nxt;
        spike_out   <= spike;
        spike_valid <= 1'b1;
        step_cnt    <= step_cnt + SW'(1);
        run_cnt     <= run_cnt + COUNT_W'(spike);
        gap_cnt     <= '0;
      end
      if (state == GAP && !abort) gap_cnt <= gap_cnt + GW'(1);
      if (finish) begin
        frame_done  <= 1'b1;
        spike_count <= run_cnt;
      end
      if (state != IDLE && state_d == IDLE) busy <= 1'b0;
    end
  end

endmodule
